line_mem_arbiter: RTL

Two-port arbiter that shares the single line-granular main memory between two cache controllers (port 0: instruction cache, port 1: data cache). It sits between the caches' memory-bus side and the `main_mem` instance. It selects one owner at a time with round-robin fairness, muxes address and write line to memory, and routes the `gnt` pulse back to the owner. It also keeps per-port transaction and wait-cycle counters for performance reporting.

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/perf_cnt.sv | 20 ++
 rtl/line_mem_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the line-granular memory bus.
package mem_bus_pkg;

  localparam int DEF_LINE_ADDR_LEN = 3;
  localparam int WORD_W            = 32;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_t;

  typedef logic [(1 << DEF_LINE_ADDR_LEN)-1:0][WORD_W-1:0] line_t;

  // Port indices as stored in the arbiter's last-served bit.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/perf_cnt.sv
// Free-running performance counter with enable; wraps modulo 2^CNT_W.
module perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // Count one per enabled cycle; synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/line_mem_arbiter.sv
// Round-robin arbiter sharing main memory between the I-cache (port 0)
// and D-cache (port 1), with per-port transaction and wait counters.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending ports, mem requests held low
// OWN0  | port 0 owns memory until mem_gnt or until it drops its request
// OWN1  | port 1 owns memory until mem_gnt or until it drops its request
module line_mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9,
  parameter int CNT_W         = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 p0_rd_req,
  input  logic                                 p0_wr_req,
  input  logic [ADDR_LEN-1:0]                  p0_addr,
  input  logic [(WORD_W << LINE_ADDR_LEN)-1:0] p0_wr_line,
  output logic                                 p0_gnt,
  output logic [(WORD_W << LINE_ADDR_LEN)-1:0] p0_rd_line,
  input  logic                                 p1_rd_req,
  input  logic                                 p1_wr_req,
  input  logic [ADDR_LEN-1:0]                  p1_addr,
  input  logic [(WORD_W << LINE_ADDR_LEN)-1:0] p1_wr_line,
  output logic                                 p1_gnt,
  output logic [(WORD_W << LINE_ADDR_LEN)-1:0] p1_rd_line,
  output logic                                 mem_rd_req,
  output logic                                 mem_wr_req,
  output logic [ADDR_LEN-1:0]                  mem_addr,
  output logic [(WORD_W << LINE_ADDR_LEN)-1:0] mem_wr_line,
  input  logic [(WORD_W << LINE_ADDR_LEN)-1:0] mem_rd_line,
  input  logic                                 mem_gnt,
  output logic [CNT_W-1:0]                     p0_txn_cnt,
  output logic [CNT_W-1:0]                     p1_txn_cnt,
  output logic [CNT_W-1:0]                     p0_wait_cnt,
  output logic [CNT_W-1:0]                     p1_wait_cnt
);

  arb_state_t state;
  logic       last;
  logic       p0_pend;
  logic       p1_pend;

  assign p0_pend = p0_rd_req | p0_wr_req;
  assign p1_pend = p1_rd_req | p1_wr_req;

  // Read data is not owner-qualified; each cache only consumes it on its gnt.
  assign p0_rd_line = mem_rd_line;
  assign p1_rd_line = mem_rd_line;

  // Ownership FSM and last-served bit; a ported drop of requests aborts
  // the transaction without touching fairness state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= PORT_D;
    end else begin
      case (state)
        IDLE: begin
          if (p0_pend && p1_pend) begin
            state <= (last == PORT_D) ? OWN0 : OWN1;
          end else if (p0_pend) begin
            state <= OWN0;
          end else if (p1_pend) begin
            state <= OWN1;
          end
        end
        OWN0: begin
          if (mem_gnt) begin
            state <= IDLE;
            last  <= PORT_I;
          end else if (!p0_pend) begin
            state <= IDLE;
          end
        end
        OWN1: begin
          if (mem_gnt) begin
            state <= IDLE;
            last  <= PORT_D;
          end else if (!p1_pend) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Route the owner's request, address and write line to memory and the
  // memory completion back to the owner only.
  always_comb begin
    mem_rd_req  = 1'b0;
    mem_wr_req  = 1'b0;
    mem_addr    = p0_addr;
    mem_wr_line = p0_wr_line;
    p0_gnt      = 1'b0;
    p1_gnt      = 1'b0;
    case (state)
      OWN0: begin
        mem_rd_req = p0_rd_req;
        mem_wr_req = p0_wr_req;
        p0_gnt     = mem_gnt;
      end
      OWN1: begin
        mem_rd_req  = p1_rd_req;
        mem_wr_req  = p1_wr_req;
        mem_addr    = p1_addr;
        mem_wr_line = p1_wr_line;
        p1_gnt      = mem_gnt;
      end
      default: ;
    endcase
  end

  perf_cnt #(.CNT_W(CNT_W)) u_p0_txn (
    .clk (clk),
    .rst (rst),
    .en  ((state == OWN0) && mem_gnt),
    .cnt (p0_txn_cnt)
  );

  perf_cnt #(.CNT_W(CNT_W)) u_p1_txn (
    .clk (clk),
    .rst (rst),
    .en  ((state == OWN1) && mem_gnt),
    .cnt (p1_txn_cnt)
  );

  perf_cnt #(.CNT_W(CNT_W)) u_p0_wait (
    .clk (clk),
    .rst (rst),
    .en  (p0_pend && (state != OWN0)),
    .cnt (p0_wait_cnt)
  );

  perf_cnt #(.CNT_W(CNT_W)) u_p1_wait (
    .clk (clk),
    .rst (rst),
    .en  (p1_pend && (state != OWN1)),
    .cnt (p1_wait_cnt)
  );

endmodule
